// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinationally read single-port RAM
// between the MEM stage (port 0) and a bus/DMA master (port 1).
module data_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rdy,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rdy,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner;      // port currently holding the RAM
  logic   last;       // port granted most recently
  logic   grant;
  logic   grant_port;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant      = 1'b1;
          grant_port = (m0_req && m1_req) ? ~last : m1_req;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        // The owner's own request is ignored here; only the other port may be granted.
        if (owner ? m0_req : m1_req) begin
          grant      = 1'b1;
          grant_port = ~owner;
          state_nxt  = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_rdy    <= 1'b0;
      m1_rdy    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state  <= state_nxt;
      m0_rdy <= 1'b0;
      m1_rdy <= 1'b0;
      if (grant) begin
        owner     <= grant_port;
        last      <= grant_port;
        ram_we    <= grant_port ? m1_we    : m0_we;
        ram_addr  <= grant_port ? m1_addr  : m0_addr;
        ram_wdata <= grant_port ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS) begin
        // The write pulse lasts exactly the ACCESS cycle; the RAM writes on level.
        ram_we <= 1'b0;
        if (owner) m1_rdy <= 1'b1;
        else       m0_rdy <= 1'b1;
        if (!ram_we) begin
          if (owner) m1_rdata <= ram_rdata;
          else       m0_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized two-master traffic against a transaction model.
module tb_data_ram_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req, we, rdy;
  logic [ADDR_W-1:0]   addr  [2];
  logic [DATA_W-1:0]   wdata [2];
  logic [DATA_W-1:0]   rdata0, rdata1;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;

  logic [DATA_W-1:0]   mem     [0:4095];  // the RAM the arbiter drives
  logic [DATA_W-1:0]   ref_mem [0:4095];  // bench's expected RAM contents

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_rdy(rdy[0]), .m0_rdata(rdata0),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_rdy(rdy[1]), .m1_rdata(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] port_rdata(input int p);
    return (p == 1) ? rdata1 : rdata0;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_ram_we"},    32'(ram_we),    32'h0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'h0);
    check({tag, "_ram_wdata"}, ram_wdata,      32'h0);
    check({tag, "_rdy"},       32'(rdy),       32'h0);
    check({tag, "_rdata0"},    rdata0,         32'h0);
    check({tag, "_rdata1"},    rdata1,         32'h0);
  endtask

  // Protocol invariants during random traffic.
  logic [1:0] prev_rdy = 2'b00;
  logic       prev_we  = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_rdy_both",   32'(rdy[0] & rdy[1]), 32'h0);
      check("mon_rdy_width",  32'(|(prev_rdy & rdy)), 32'h0);
      check("mon_we_width",   32'(prev_we & ram_we), 32'h0);
    end
    prev_rdy = rdy;
    prev_we  = ram_we;
  end

  // One isolated transaction from an idle arbiter: checks latency, data and write pulse.
  task automatic do_txn(input int p, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp,
                        input string tag);
    int lat = 0, we_cycles = 0, other_rdy = 0;
    repeat (2) @(negedge clk);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_we) we_cycles++;
      if (rdy[1-p]) other_rdy++;
      if (rdy[p]) begin
        lat = c;
        check({tag, "_rdata"}, port_rdata(p), exp);
        break;
      end
    end
    req[p] = 1'b0;
    check({tag, "_latency"},   32'(lat), 32'd2);
    check({tag, "_we_cycles"}, 32'(we_cycles), w ? 32'd1 : 32'd0);
    check({tag, "_other_rdy"}, 32'(other_rdy), 32'd0);
  endtask

  // Both ports read at the same edge; port 0 must win, then port 1 with no bubble.
  task automatic both_read(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                           input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                           input string tag);
    int k0 = 0, k1 = 0;
    @(negedge clk);
    req = 2'b11; we = 2'b00; addr[0] = a0; addr[1] = a1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rdy[0] && k0 == 0) begin
        k0 = k; req[0] = 1'b0;
        check({tag, "_rdata0"}, rdata0, e0);
      end
      if (rdy[1] && k1 == 0) begin
        k1 = k; req[1] = 1'b0;
        check({tag, "_rdata1"}, rdata1, e1);
      end
    end
    req = 2'b00;
    check({tag, "_lat0"}, 32'(k0), 32'd2);
    check({tag, "_lat1"}, 32'(k1), 32'd4);
  endtask

  // Randomized master; expectations come from ref_mem and the last read per port.
  logic [ADDR_W-1:0] addr_set [8] = '{12'h000, 12'h001, 12'h002, 12'h003,
                                       12'h7FF, 12'h800, 12'hFFE, 12'hFFF};
  logic [DATA_W-1:0] last_rd [2];

  task automatic run_port(input int p, input int n);
    logic              t_we;
    logic [ADDR_W-1:0] t_a;
    logic [DATA_W-1:0] t_d;
    logic              got;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      t_we = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      t_a  = addr_set[$urandom_range(0, 7)];
      t_d  = $urandom;
      req[p] = 1'b1; we[p] = t_we; addr[p] = t_a; wdata[p] = t_d;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = rdy[p];
      end
      check($sformatf("rnd_p%0d_done", p), 32'(got), 32'h1);
      if (got) begin
        if (t_we) begin
          ref_mem[t_a] = t_d;
          check($sformatf("rnd_p%0d_wr_hold", p), port_rdata(p), last_rd[p]);
        end else begin
          check($sformatf("rnd_p%0d_rd_%h", p, t_a), port_rdata(p), ref_mem[t_a]);
          last_rd[p] = ref_mem[t_a];
        end
      end
      req[p] = 1'b0;
    end
  endtask

  typedef struct {
    int                p;
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;  // expected mX_rdata while rdy
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_port, cnt, last_k;
    int served [2];

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h000] = 32'hCAFE0000;
    mem[12'h001] = 32'h00000011;
    mem[12'h002] = 32'h00000022;

    // Writes leave the port's rdata at its previous read value.
    vecs[0] = '{0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 12'h020, 32'h12345678, 32'h00000000};
    vecs[3] = '{1, 1'b0, 12'h020, 32'h0,        32'h12345678};
    vecs[4] = '{0, 1'b0, 12'h020, 32'h0,        32'h12345678};
    vecs[5] = '{1, 1'b1, 12'hFFF, 32'hA5A5A5A5, 32'h12345678};
    vecs[6] = '{0, 1'b0, 12'hFFF, 32'h0,        32'hA5A5A5A5};
    vecs[7] = '{0, 1'b0, 12'h000, 32'h0,        32'hCAFE0000};
    vecs[8] = '{1, 1'b1, 12'h000, 32'h5555AAAA, 32'h12345678};
    vecs[9] = '{1, 1'b0, 12'h000, 32'h0,        32'h5555AAAA};

    rst_n = 1'b0; req = 2'b00; we = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    foreach (vecs[i])
      do_txn(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));

    // Simultaneous reads right after reset.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    both_read(12'h001, 12'h002, 32'h11, 32'h22, "both");

    // Continuous requests from both ports: strict alternation, port 0 first.
    repeat (3) @(negedge clk);
    req = 2'b11; we = 2'b00; addr[0] = 12'h001; addr[1] = 12'h002;
    exp_port = 0; cnt = 0; last_k = 0; served[0] = 0; served[1] = 0;
    for (int k = 1; k <= 40 && cnt < 8; k++) begin
      @(negedge clk);
      if (rdy != 2'b00) begin
        check($sformatf("alt_port%0d", cnt), 32'(rdy[1]), 32'(exp_port));
        if (cnt > 0) check($sformatf("alt_gap%0d", cnt), 32'(k - last_k), 32'd2);
        served[rdy[1]]++;
        last_k = k;
        cnt++;
        exp_port = 1 - exp_port;
        if (cnt == 8) req = 2'b00;
      end
    end
    req = 2'b00;
    check("alt_total", 32'(cnt), 32'd8);
    check("alt_served0", 32'(served[0]), 32'd4);
    check("alt_served1", 32'(served[1]), 32'd4);

    // Reset during ACCESS of a port-0 write drops it without rdy or RAM write.
    repeat (3) @(negedge clk);
    mem[12'h050] = 32'h0BADF00D;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h050; wdata[0] = 32'h12345678;
    @(posedge clk);
    #2;
    check("rstmid_we_before", 32'(ram_we), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset("rstmid");
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdy != 2'b00) cnt++;
    end
    check("rstmid_no_rdy", 32'(cnt), 32'h0);
    check("rstmid_no_write", mem[12'h050], 32'h0BADF00D);
    both_read(12'h001, 12'h002, 32'h11, 32'h22, "after_rst");

    // Randomized concurrent traffic.
    foreach (addr_set[i]) begin
      logic [DATA_W-1:0] v;
      v = $urandom;
      mem[addr_set[i]]     = v;
      ref_mem[addr_set[i]] = v;
    end
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    fork
      run_port(0, 40);
      run_port(1, 40);
    join
    repeat (4) @(negedge clk);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
